// File: rtl/term_pkg.sv
// Shared constants for the console path: feeder FSM states and the control
// characters the text engine interprets.
package term_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam byte_t CH_LF = 8'h0A;
  localparam byte_t CH_CR = 8'h0D;
  localparam byte_t CH_FF = 8'h0C;
  localparam byte_t CH_BS = 8'h08;

endpackage

// File: rtl/term_fifo.sv
// Circular byte FIFO with a registered occupancy counter and sticky overflow.
// Read data is the entry at the read pointer; a push is never visible the same cycle.
module term_fifo
  import term_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk25,
  input  logic                rst,
  input  logic                push_i,
  input  byte_t               push_data_i,
  input  logic                pop_i,
  output byte_t               rd_data_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  byte_t                 mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push_ok_s, pop_ok_s;

  // Full check uses the pre-cycle count, so a simultaneous pop cannot rescue a push.
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok_s  = push_i & ~full_o;
  assign pop_ok_s   = pop_i & ~empty_o;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    wr_ptr_d   = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop_ok_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (push_i & full_o);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk25) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/term_feeder.sv
// Rate matcher between the core's console byte stream and the text engine:
// queues bytes and issues one per engine-ready window, then holds off HOLD cycles.
module term_feeder
  import term_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int HOLD       = 2
) (
  input  logic                clk25,
  input  logic                rst,
  input  logic                in_wr,
  input  logic [7:0]          in_data,
  output logic                in_full,
  output logic                out_wr,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  logic [0:0] state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       out_wr_q, out_wr_d;
  byte_t      out_data_q, out_data_d;
  logic       pop_s;
  logic       empty_s;
  byte_t      rd_data_s;

  term_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk25      (clk25),
    .rst        (rst),
    .push_i     (in_wr),
    .push_data_i(in_data),
    .pop_i      (pop_s),
    .rd_data_o  (rd_data_s),
    .count_o    (count),
    .full_o     (in_full),
    .empty_o    (empty_s),
    .overflow_o (overflow)
  );

  // HOLD masks out_ready while the engine's ready flag lags behind our strobe.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && out_ready) begin
          out_wr_d   = 1'b1;
          out_data_d = rd_data_s;
          pop_s      = 1'b1;
          hold_cnt_d = HOLD_CNT;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q - 4'd1;
        if (hold_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 4'd0;
      out_wr_q   <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_term_feeder.sv
// Self-checking bench for term_feeder: directed vector table, corner-case
// sequences and a randomized run against a queue-based timing model.
module tb_term_feeder;
  import term_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int HOLD       = 2;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       in_wr;
  logic [7:0] in_data;
  logic       in_full;
  logic       out_wr;
  logic [7:0] out_data;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;

  term_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .HOLD(HOLD)) dut (
    .clk25    (clk25),
    .rst      (rst),
    .in_wr    (in_wr),
    .in_data  (in_data),
    .in_full  (in_full),
    .out_wr   (out_wr),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
  );

  initial forever #5 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted bytes plus the issue-spacing rule.
  logic [7:0] mq[$];
  logic       m_wr;
  logic [7:0] m_data;
  logic       m_ovf;
  int         cyc = 0;
  int         last_iss;
  logic [7:0] iss_data[$];
  int         iss_cyc[$];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic       e_wr;
    logic [7:0] e_data;
    int         e_cnt;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wr     = 1'b0;
    m_data   = 8'h00;
    m_ovf    = 1'b0;
    last_iss = -1000;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic rdy);
    bit was_full;
    cyc++;
    was_full = (mq.size() == DEPTH);
    if (mq.size() > 0 && rdy && (cyc - last_iss >= HOLD + 1)) begin
      m_data   = mq.pop_front();
      m_wr     = 1'b1;
      last_iss = cyc;
    end else begin
      m_wr = 1'b0;
    end
    if (wr) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("out_wr", out_wr, m_wr);
    chk("out_data", out_data, m_data);
    chk("count", count, mq.size());
    chk("in_full", in_full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic step(input logic wr, input logic [7:0] d, input logic rdy);
    in_wr     = wr;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk25);
    model_edge(wr, d, rdy);
    #1;
    check_model();
    if (out_wr === 1'b1) begin
      iss_data.push_back(out_data);
      iss_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    in_wr = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", count, 5'd0);
    chk("rst_in_full", in_full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    model_reset();
    @(posedge clk25);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int rdy_pct;
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0};
    tbl[3]  = '{1'b1, 8'h31, 1'b1, 1'b0, 8'h41, 1};
    tbl[4]  = '{1'b1, 8'h32, 1'b1, 1'b1, 8'h31, 1};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h31, 2};
    tbl[6]  = '{1'b1, 8'h34, 1'b1, 1'b0, 8'h31, 3};
    tbl[7]  = '{1'b1, 8'h35, 1'b1, 1'b1, 8'h32, 3};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h32, 3};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h32, 3};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 2};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h34, 1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h34, 1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h35, 0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h35, 0};

    rst = 1'b1; in_wr = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk25);
    #1;
    do_reset();

    // Single byte latency and HOLD=2 burst spacing.
    base = iss_cyc.size();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rdy);
      chk("tbl_out_wr", out_wr, tbl[i].e_wr);
      chk("tbl_out_data", out_data, tbl[i].e_data);
      chk("tbl_count", count, tbl[i].e_cnt);
      chk("tbl_overflow", overflow, 1'b0);
    end
    chk("burst_pulses", iss_cyc.size() - base, 6);
    for (int i = base + 2; i < iss_cyc.size(); i++)
      chk("burst_gap", iss_cyc[i] - iss_cyc[i-1], HOLD + 1);

    // Engine busy for 100 cycles, then the queued bytes go out in order.
    base = iss_cyc.size();
    step(1'b1, CH_LF, 1'b0);
    step(1'b1, 8'h58, 1'b0);
    for (int i = 0; i < 98; i++) step(1'b0, 8'h00, 1'b0);
    chk("busy_no_issue", iss_cyc.size() - base, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    chk("busy_issued", iss_cyc.size() - base, 2);
    if (iss_cyc.size() - base == 2) begin
      chk("busy_first", iss_data[base], CH_LF);
      chk("busy_second", iss_data[base+1], 8'h58);
      chk("busy_gap", iss_cyc[base+1] - iss_cyc[base], HOLD + 1);
    end

    // Fill past full: the 17th byte is dropped, the first 16 drain intact.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'h60 + 8'(i), 1'b0);
      if (i == 14) chk("fill_not_full", in_full, 1'b0);
      if (i == 15) chk("fill_full", in_full, 1'b1);
    end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", count, 5'd16);
    base = iss_cyc.size();
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_n", iss_cyc.size() - base, 16);
    for (int i = 0; i < 16 && base + i < iss_data.size(); i++)
      chk("drain_byte", iss_data[base+i], 8'h60 + 8'(i));
    chk("ovf_sticky", overflow, 1'b1);

    // Full plus a push on the issue cycle: push is still dropped.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("fp_out_wr", out_wr, 1'b1);
    chk("fp_out_data", out_data, 8'h80);
    chk("fp_count", count, 5'd15);
    chk("fp_overflow", overflow, 1'b1);
    base = iss_cyc.size();
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b1);
    chk("fp_drain_n", iss_cyc.size() - base, 15);
    if (iss_data.size() > 0) chk("fp_last", iss_data[iss_data.size()-1], 8'h8F);

    // Asynchronous reset one cycle after an issue with 5 bytes still queued.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mh_pulse", out_wr, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("mh_queued", count, 5'd5);
    do_reset();
    base = iss_cyc.size();
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
    chk("mh_quiet", iss_cyc.size() - base, 0);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("mh_new_n", iss_cyc.size() - base, 1);
    if (iss_cyc.size() - base == 1) chk("mh_new_byte", iss_data[base], 8'h55);

    // Randomized traffic against the model.
    rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) rdy_pct = $urandom_range(0, 100);
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < rdy_pct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
